// File: rtl/i2s_rx_deserializer.sv
// I2S receiver: oversamples the I2S pins in the clk domain, captures
// MSB-first words per channel and presents completed L/R pairs with a
// one-cycle out_valid strobe. Short words are zero-padded and flagged.
module i2s_rx_deserializer #(
  parameter int DATA_WIDTH  = 24,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i2s_sclk,
  input  logic                  i2s_lrclk,
  input  logic                  i2s_sd,
  output logic [DATA_WIDTH-1:0] out_L,
  output logic [DATA_WIDTH-1:0] out_R,
  output logic                  out_valid,
  output logic                  frame_err
);

  localparam int CW = $clog2(DATA_WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LEFT  = 2'd1,
    RIGHT = 2'd2
  } state_t;

  logic [SYNC_STAGES-1:0] sclk_sync;
  logic [SYNC_STAGES-1:0] lr_sync;
  logic [SYNC_STAGES-1:0] sd_sync;
  logic                   sclk_prev;
  logic                   rise;
  logic                   lr_smp;
  logic                   sd_smp;
  logic                   lr_d;
  logic [CW-1:0]          cnt;
  logic [DATA_WIDTH-1:0]  shreg;
  logic [DATA_WIDTH-1:0]  word;
  logic [DATA_WIDTH-1:0]  hold_L;
  state_t                 state;
  state_t                 state_next;
  logic                   boundary;
  logic                   shift_en;
  logic                   clear_word;
  logic                   commit_left;
  logic                   commit_right;
  logic                   word_short;

  // Synchronizer chains for the three asynchronous I2S pins, plus previous synced sclk
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync <= '0;
      lr_sync   <= '0;
      sd_sync   <= '0;
      sclk_prev <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], i2s_sclk};
      lr_sync   <= {lr_sync[SYNC_STAGES-2:0], i2s_lrclk};
      sd_sync   <= {sd_sync[SYNC_STAGES-2:0], i2s_sd};
      sclk_prev <= sclk_sync[SYNC_STAGES-1];
    end
  end

  // Registered sclk rise pulse, with lr/sd sampled in the same cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rise   <= 1'b0;
      lr_smp <= 1'b0;
      sd_smp <= 1'b0;
    end else begin
      rise   <= sclk_sync[SYNC_STAGES-1] & ~sclk_prev;
      lr_smp <= lr_sync[SYNC_STAGES-1];
      sd_smp <= sd_sync[SYNC_STAGES-1];
    end
  end

  assign boundary   = rise && (lr_smp != lr_d);
  // Short if the bit arriving now does not bring the count up to a full word
  assign word_short = (cnt < CW'(DATA_WIDTH - 1));

  // Current word with the sampled bit merged at position DATA_WIDTH-1-cnt;
  // once cnt saturates no position matches, so padding bits fall away.
  genvar gi;
  generate
    for (gi = 0; gi < DATA_WIDTH; gi++) begin : g_bit
      assign word[gi] = (cnt == CW'(DATA_WIDTH - 1 - gi)) ? sd_smp : shreg[gi];
    end
  endgenerate

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // FSM next state: only boundaries move the FSM; IDLE waits for a boundary into left
  always_comb begin
    state_next = state;
    if (boundary) begin
      case (state)
        IDLE:    state_next = lr_smp ? IDLE : LEFT;
        LEFT:    state_next = RIGHT;
        RIGHT:   state_next = LEFT;
        default: state_next = IDLE;
      endcase
    end
  end

  // FSM outputs: datapath controls for shifting, clearing and committing words
  always_comb begin
    shift_en     = 1'b0;
    clear_word   = 1'b0;
    commit_left  = 1'b0;
    commit_right = 1'b0;
    if (rise) begin
      if (lr_smp != lr_d) begin
        clear_word   = 1'b1;
        commit_left  = (state == LEFT);
        commit_right = (state == RIGHT);
      end else if (state != IDLE && cnt < CW'(DATA_WIDTH)) begin
        shift_en = 1'b1;
      end
    end
  end

  // Datapath: bit capture, word commits and output strobes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lr_d      <= 1'b0;
      cnt       <= '0;
      shreg     <= '0;
      hold_L    <= '0;
      out_L     <= '0;
      out_R     <= '0;
      out_valid <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      frame_err <= 1'b0;
      if (rise) lr_d <= lr_smp;
      if (clear_word) begin
        cnt   <= '0;
        shreg <= '0;
      end else if (shift_en) begin
        cnt   <= cnt + CW'(1);
        shreg <= word;
      end
      if (commit_left) begin
        hold_L    <= word;
        frame_err <= word_short;
      end
      if (commit_right) begin
        out_L     <= hold_L;
        out_R     <= word;
        out_valid <= 1'b1;
        frame_err <= word_short;
      end
    end
  end

endmodule

// File: tb/tb_i2s_rx_deserializer.sv
// Scoreboard bench for i2s_rx_deserializer: an I2S transmitter model drives
// whole slots; expected pairs and error strobes are queued at the pin-level
// boundary rise and checked by an independent monitor.
module tb_i2s_rx_deserializer;

  localparam int W    = 24;
  localparam int SS   = 2;
  localparam int HALF = 4;   // clk cycles per sclk half period (clk = 8x sclk)

  logic          clk;
  logic          rst_n;
  logic          i2s_sclk;
  logic          i2s_lrclk;
  logic          i2s_sd;
  logic [W-1:0]  out_L;
  logic [W-1:0]  out_R;
  logic          out_valid;
  logic          frame_err;

  i2s_rx_deserializer #(.DATA_WIDTH(W), .SYNC_STAGES(SS)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .i2s_sclk  (i2s_sclk),
    .i2s_lrclk (i2s_lrclk),
    .i2s_sd    (i2s_sd),
    .out_L     (out_L),
    .out_R     (out_R),
    .out_valid (out_valid),
    .frame_err (frame_err)
  );

  typedef struct {
    logic [W-1:0] l;
    logic [W-1:0] r;
    int           cyc;
  } exp_t;

  exp_t vq[$];
  int   eq[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;

  // Transmitter-side knowledge of the stream
  logic         lr_prev;
  logic         carry;
  logic         open_lr;
  logic         open_elig;
  logic         open_short;
  logic [W-1:0] open_exp;
  logic [W-1:0] hold_exp;
  logic         killed;
  int           reset_at_bit = -1;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, got, want, $time);
    end
  endtask

  // Slot data left-justified into a W-bit word: extra bits dropped, missing bits zero
  function automatic logic [W-1:0] justify(input logic [63:0] d, input int s);
    logic [63:0] t;
    if (s >= W) t = d >> (s - W);
    else        t = d << (W - s);
    return t[W-1:0];
  endfunction

  task automatic do_reset3();
    rst_n = 1'b0;
    #1;
    check("reset_mid_outputs", {out_L, out_R, out_valid, frame_err}, 64'd0);
    repeat (3) @(negedge clk);
    rst_n     = 1'b1;
    lr_prev   = 1'b0;
    open_elig = 1'b0;
    open_lr   = 1'b0;
    hold_exp  = '0;
    killed    = 1'b1;
    $display("reset pulse applied mid left word at t=%0t", $time);
  endtask

  // One I2S slot: lr=v for s sclk periods. The first rise carries the
  // previous word's last bit (one-bit delay); data MSB follows.
  task automatic send_slot(input logic v, input int s, input logic [63:0] data);
    logic new_elig;
    logic b;
    new_elig = 1'b0;
    killed   = 1'b0;
    for (int k = 0; k < s; k++) begin
      b = (k == 0) ? carry : data[s-k];
      @(negedge clk);
      i2s_sclk  = 1'b0;
      i2s_lrclk = v;
      i2s_sd    = b;
      if (reset_at_bit == k && v == 1'b0) begin
        do_reset3();
        reset_at_bit = -1;
      end
      repeat (HALF) @(negedge clk);
      i2s_sclk = 1'b1;
      if (k == 0 && v != lr_prev) begin
        if (open_elig) begin
          if (!open_lr) begin
            hold_exp = open_exp;
            if (open_short) eq.push_back(cyc);
          end else begin
            vq.push_back('{hold_exp, open_exp, cyc});
            if (open_short) eq.push_back(cyc);
          end
        end
        new_elig = (v == 1'b0) ? 1'b1 : (open_elig && !open_lr);
      end
      lr_prev = v;
      repeat (HALF - 1) @(negedge clk);
    end
    carry      = data[0];
    open_lr    = v;
    open_elig  = new_elig && !killed;
    open_exp   = justify(data, s);
    open_short = (s < W);
  endtask

  task automatic send_frame(input int s, input logic [63:0] l, input logic [63:0] r);
    $display("frame: slot=%0d L=%0h R=%0h", s, l, r);
    send_slot(1'b0, s, l);
    send_slot(1'b1, s, r);
  endtask

  // Monitor: every strobe pops the oldest expectation and compares
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid) begin
        if (vq.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_out_valid: got L=%0h R=%0h expected no strobe", out_L, out_R);
        end else begin
          exp_t e;
          e = vq.pop_front();
          $display("pair: L=%0h R=%0h expected L=%0h R=%0h latency=%0d", out_L, out_R, e.l, e.r, cyc - e.cyc);
          check("out_L", 64'(out_L), 64'(e.l));
          check("out_R", 64'(out_R), 64'(e.r));
          check("valid_latency", 64'(cyc - e.cyc), 64'(SS + 2));
        end
      end
      if (frame_err) begin
        if (eq.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_frame_err: got 1 expected 0 (t=%0t)", $time);
        end else begin
          int c;
          c = eq.pop_front();
          $display("frame_err strobe latency=%0d", cyc - c);
          check("err_latency", 64'(cyc - c), 64'(SS + 2));
        end
      end
    end
  end

  initial begin
    logic [63:0] l;
    logic [63:0] r;
    int          s;
    int          sizes [5];
    sizes     = '{16, 20, 24, 28, 32};
    lr_prev   = 1'b0;
    carry     = 1'b0;
    open_lr   = 1'b0;
    open_elig = 1'b0;
    open_short = 1'b0;
    open_exp  = '0;
    hold_exp  = '0;
    killed    = 1'b0;

    // Reset held while the pins toggle
    rst_n     = 1'b0;
    i2s_sclk  = 1'b0;
    i2s_lrclk = 1'b0;
    i2s_sd    = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      i2s_sclk  = 1'($urandom_range(0, 1));
      i2s_lrclk = 1'($urandom_range(0, 1));
      i2s_sd    = 1'($urandom_range(0, 1));
      if (i % 4 == 3) check("reset_hold_outputs", {out_L, out_R, out_valid, frame_err}, 64'd0);
    end
    @(negedge clk);
    i2s_sclk  = 1'b0;
    i2s_lrclk = 1'b0;
    i2s_sd    = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check("idle_outputs", {out_L, out_R, out_valid, frame_err}, 64'd0);

    // Stream starts mid right word
    send_slot(1'b1, 10, 64'($urandom));

    // 32-bit slots with padding
    for (int i = 0; i < 4; i++) send_frame(32, 64'h12345600, 64'hABCDEF00);

    // 16-bit slots: short words
    for (int i = 0; i < 2; i++) send_frame(16, 64'hBEEF, 64'h0001);

    // Exact 24-bit slots: boundary bit is the LSB
    for (int i = 0; i < 2; i++) send_frame(24, 64'h800001, 64'h7FFFFE);

    // Random slot widths and data
    for (int i = 0; i < 6; i++) begin
      s = sizes[$urandom_range(0, 4)];
      l = {$urandom, $urandom} & ((64'd1 << s) - 64'd1);
      r = {$urandom, $urandom} & ((64'd1 << s) - 64'd1);
      send_frame(s, l, r);
    end

    // Reset in the middle of a left word of a running stream
    reset_at_bit = 10;
    send_frame(32, 64'hCAFE1200, 64'h33445500);
    send_frame(32, 64'h0A0B0C00, 64'hF0E0D000);
    send_frame(24, 64'h5A5A5A, 64'hA5A5A5);

    // Close the last right word, then drain
    send_slot(1'b0, 4, 64'd0);
    repeat (20) @(negedge clk);
    check("pending_valid_count", 64'(vq.size()), 64'd0);
    check("pending_err_count", 64'(eq.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
